// File: rtl/cic_interpolator_if.sv
// Sample-stream bus for cic_interpolator: low-rate input handshake in,
// full-rate filtered output and status out.
interface cic_interpolator_if #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 16
);
  logic signed [IN_W-1:0]  in;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [OUT_W-1:0] out;
  logic                    out_valid;
  logic                    underrun;

  // Sample source / output consumer side
  modport master (
    output in,
    output in_valid,
    input  in_ready,
    input  out,
    input  out_valid,
    input  underrun
  );

  // Filter side
  modport slave (
    input  in,
    input  in_valid,
    output in_ready,
    output out,
    output out_valid,
    output underrun
  );
endinterface

// File: rtl/cic_interpolator.sv
// CIC interpolating filter: N comb stages at the low rate (one slot every R
// clocks), zero-stuffing, N pipelined integrators at clock rate, then scaling
// by R^(N-1) back to the input range.
// Optional build macro CIC_INTERP_SAT_EN: clamp the scaled result to the
// IN_W signed range instead of letting it wrap.
module cic_interpolator #(
  parameter int unsigned N     = 3,
  parameter int unsigned R     = 8,
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 16
) (
  input  logic              aclk,
  input  logic              aresetn,
  cic_interpolator_if.slave bus
);

  localparam int unsigned LOG2R = $clog2(R);
  localparam int unsigned W     = IN_W + N * LOG2R;
  localparam int unsigned SHIFT = (N - 1) * LOG2R;
  localparam int unsigned S_W   = IN_W + LOG2R;

  logic [LOG2R-1:0]        phase;
  logic                    in_ready_c;
  logic                    accept_c;
  logic                    starve_c;

  logic signed [W-1:0]     c_c [N+1];
  logic signed [W-1:0]     d_q [N];
  logic signed [W-1:0]     u_q;
  logic signed [W-1:0]     integ_q [N];

  logic signed [IN_W-1:0]  t_c;
  logic signed [OUT_W-1:0] out_q;
  logic [N:0]              vld_sr;
  logic                    out_valid_q;
  logic                    underrun_q;

  // Slot decode; held low while in reset so no transfer is advertised
  assign in_ready_c = aresetn && (phase == '0);
  assign accept_c   = in_ready_c && bus.in_valid;
  assign starve_c   = in_ready_c && !bus.in_valid;

  assign bus.in_ready  = in_ready_c;
  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.underrun  = underrun_q;

  // Free-running phase counter; R is a power of two so it wraps naturally
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      phase <= '0;
    end else begin
      phase <= phase + LOG2R'(1);
    end
  end

  // Comb chain evaluated combinationally within the slot cycle; a missed
  // slot feeds zero into the chain
  always_comb begin
    c_c[0] = accept_c ? W'(bus.in) : '0;
    for (int k = 0; k < N; k++) begin
      c_c[k+1] = c_c[k] - d_q[k];
    end
  end

  // Comb delay registers advance only on slots; u carries the comb result
  // for the single cycle after a slot and is zero otherwise (zero-stuffing)
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int k = 0; k < N; k++) begin
        d_q[k] <= '0;
      end
      u_q <= '0;
    end else begin
      if (in_ready_c) begin
        for (int k = 0; k < N; k++) begin
          d_q[k] <= c_c[k];
        end
      end
      u_q <= in_ready_c ? c_c[N] : '0;
    end
  end

  // Integrator cascade at clock rate, each stage fed from the previous
  // stage's register (pipelined), modulo 2^W
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int k = 0; k < N; k++) begin
        integ_q[k] <= '0;
      end
    end else begin
      integ_q[0] <= integ_q[0] + u_q;
      for (int k = 1; k < N; k++) begin
        integ_q[k] <= integ_q[k] + integ_q[k-1];
      end
    end
  end

`ifdef CIC_INTERP_SAT_EN
  localparam logic [IN_W-1:0] T_MAX = {1'b0, {(IN_W-1){1'b1}}};
  localparam logic [IN_W-1:0] T_MIN = {1'b1, {(IN_W-1){1'b0}}};

  logic signed [S_W-1:0] s_c;
  logic                  in_range_c;

  assign s_c = integ_q[N-1][W-1:SHIFT];

  // Remove the R^(N-1) gain and clamp into the IN_W signed range; the value
  // fits when all bits from the IN_W sign position upward agree
  always_comb begin
    in_range_c = (&s_c[S_W-1:IN_W-1]) || !(|s_c[S_W-1:IN_W-1]);
    t_c        = s_c[IN_W-1:0];
    if (!in_range_c) begin
      t_c = s_c[S_W-1] ? T_MIN : T_MAX;
    end
  end
`else
  // Remove the R^(N-1) gain and keep the low IN_W bits; overshoot wraps
  assign t_c = integ_q[N-1][SHIFT +: IN_W];
`endif

  // Registered output taken from the top OUT_W bits of the scaled value
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_q <= '0;
    end else begin
      out_q <= t_c[IN_W-1 -: OUT_W];
    end
  end

  // Valid tracks the first accepted sample through u, N integrators and out
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      vld_sr      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      vld_sr      <= {vld_sr[N-1:0], vld_sr[0] | accept_c};
      out_valid_q <= vld_sr[N];
    end
  end

  // Sticky starvation flag, cleared only by reset
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= underrun_q | starve_c;
    end
  end

endmodule

// File: tb/tb_cic_interpolator.sv
// Self-checking bench for cic_interpolator (N=3, R=8, IN_W=OUT_W=16).
// Reference: zero-stuffed input convolved with the CIC impulse response
// (boxcar of length R convolved N times), reduced modulo 2^W and scaled.
module tb_cic_interpolator;

  localparam int N     = 3;
  localparam int R     = 8;
  localparam int IN_W  = 16;
  localparam int OUT_W = 16;
  localparam int LOG2R = 3;
  localparam int W     = IN_W + N * LOG2R;
  localparam int SHIFT = (N - 1) * LOG2R;
  localparam int HLEN  = N * (R - 1) + 1;

  logic clk;
  logic rst_n;

  cic_interpolator_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  cic_interpolator #(.N(N), .R(R), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .aclk    (clk),
    .aresetn (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     chk_cnt = 0;
  int     err_cnt = 0;

  longint h [HLEN];
  int     xup [$];
  int     cyc;
  int     first_acc;
  int     vld_rise;
  bit     m_under;
  longint obs_out;
  bit     obs_vld;

  task automatic check(input string tag, input logic signed [63:0] got, input longint exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", tag, cyc, got, exp);
    end
  endtask

  // Expected out in cycle n (cycles counted from reset release)
  function automatic longint exp_out(input int n);
    longint y = 0;
    longint s;
    longint t;
    int     m;
    if (n < N + 2) return 0;
    m = n - N - 2;
    for (int j = 0; j < HLEN; j++) begin
      if (m - j >= 0 && m - j < xup.size()) y += h[j] * longint'(xup[m - j]);
    end
    y = y & ((longint'(1) << W) - 1);
    if (y >= (longint'(1) << (W - 1))) y -= (longint'(1) << W);
    s = y >>> SHIFT;
`ifdef CIC_INTERP_SAT_EN
    if (s > 32767) t = 32767;
    else if (s < -32768) t = -32768;
    else t = s;
`else
    t = s & 64'hFFFF;
    if (t >= 32768) t -= 65536;
`endif
    return t >>> (IN_W - OUT_W);
  endfunction

  // Hold reset for a number of cycles checking cleared outputs, release on a negedge
  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    bus.in = '0;
    bus.in_valid = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      check("rst_out", bus.out, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_underrun", bus.underrun, 0);
      check("rst_in_ready", bus.in_ready, 0);
    end
    rst_n = 1'b1;
    xup.delete();
    cyc = 0;
    first_acc = -1;
    vld_rise = -1;
    m_under = 1'b0;
  endtask

  // One clock cycle: drive, check in_ready, update model, check outputs next cycle
  task automatic step(input bit v, input int x);
    bit slot;
    bit starve;
    slot = (cyc % R) == 0;
    bus.in = IN_W'(x);
    bus.in_valid = v;
    #1;
    check("in_ready", bus.in_ready, longint'(slot));
    starve = slot && !v;
    if (slot) begin
      xup.push_back(v ? x : 0);
      if (v && first_acc < 0) first_acc = cyc;
    end else begin
      xup.push_back(0);
    end
    @(posedge clk);
    if (starve) m_under = 1'b1;
    cyc++;
    @(negedge clk);
    obs_out = longint'(bus.out);
    obs_vld = bus.out_valid;
    if (obs_vld && vld_rise < 0) vld_rise = cyc;
    check("out", bus.out, exp_out(cyc));
    check("out_valid", bus.out_valid, longint'(first_acc >= 0 && cyc >= first_acc + N + 2));
    check("underrun", bus.underrun, longint'(m_under));
  endtask

  function automatic int rnd_sample();
    return int'($urandom_range(65535)) - 32768;
  endfunction

  // Single impulse of 16384 followed by zero samples; slots stay valid
  task automatic run_impulse(input string tag);
    int nz_cnt;
    int first_nz;
    longint first_val;
    longint sum;
    nz_cnt = 0;
    first_nz = -1;
    first_val = 0;
    sum = 0;
    step(1'b1, 16384);
    for (int i = 0; i < 45; i++) begin
      if (cyc % R == 0) step(1'b1, 0);
      else step(1'($urandom_range(1)), rnd_sample());
      if (obs_out != 0) begin
        nz_cnt++;
        sum += obs_out;
        if (first_nz < 0) begin
          first_nz = cyc;
          first_val = obs_out;
        end
      end
    end
    check({tag, "_first_lat"}, first_nz - first_acc, 5);
    check({tag, "_first_val"}, first_val, 256);
    check({tag, "_nonzero_cnt"}, nz_cnt, 22);
    check({tag, "_sum"}, sum, 131072);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    longint p [$];
    longint q [$];

    // Impulse response of the CIC: boxcar(R) convolved N times
    p.push_back(1);
    for (int s = 0; s < N; s++) begin
      q.delete();
      for (int i = 0; i < p.size() + R - 1; i++) q.push_back(0);
      for (int i = 0; i < p.size(); i++)
        for (int j = 0; j < R; j++) q[i + j] += p[i];
      p = q;
    end
    for (int i = 0; i < HLEN; i++) h[i] = p[i];

    rst_n = 1'b0;
    bus.in = '0;
    bus.in_valid = 1'b0;
    cyc = 0;
    first_acc = -1;
    vld_rise = -1;
    m_under = 1'b0;

    // Reset and slot cadence
    @(negedge clk);
    do_reset(5);
    for (int i = 0; i < 17; i++) step(1'b0, 0);
    check("underrun_after_idle", bus.underrun, 1);

    // DC step
    do_reset(3);
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 60; i++) begin
        step(1'b1, 1000);
        if (cyc >= 30 && obs_out != 1000) bad++;
      end
      check("dc_valid_latency", vld_rise - first_acc, 5);
      check("dc_hold_errors", bad, 0);
      check("dc_final", obs_out, 1000);
    end

    // Impulse
    do_reset(3);
    run_impulse("imp");

    // Underrun mid-stream, then reset clears it
    do_reset(2);
    for (int i = 0; i < 30; i++) step(1'b1, rnd_sample());
    while (cyc % R != 0) step(1'b1, rnd_sample());
    step(1'b0, rnd_sample());
    check("underrun_rise", bus.underrun, 1);
    for (int i = 0; i < 30; i++) step(1'b1, rnd_sample());
    check("underrun_sticky", bus.underrun, 1);
    do_reset(2);
    #1;
    check("underrun_cleared", bus.underrun, 0);

    // Async reset between edges during an impulse response
    step(1'b1, 16384);
    for (int i = 0; i < 8; i++) step(cyc % R == 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_out", bus.out, 0);
    check("async_out_valid", bus.out_valid, 0);
    check("async_in_ready", bus.in_ready, 0);
    do_reset(2);
    run_impulse("imp2");

    // Full-scale alternation driving CIC overshoot
    do_reset(2);
    for (int i = 0; i < 160; i++) begin
      if (cyc % R == 0) step(1'b1, ((cyc / R) % 2 == 0) ? 32767 : -32768);
      else step(1'($urandom_range(1)), rnd_sample());
    end

    // Random stream with occasional starved slots
    do_reset(2);
    for (int i = 0; i < 240; i++) begin
      if (cyc % R == 0) step($urandom_range(15) != 0, rnd_sample());
      else step(1'($urandom_range(1)), rnd_sample());
    end

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/cic_interpolator.md
# cic_interpolator

CIC interpolating filter for the transmit/modulator path: accepts baseband samples at the low rate (one per R clocks) and produces a continuous full-rate, clock-rate sample stream. It is the counterpart of the decimating filter chain on the receive/detector side. Its output drives the mixer/modulator together with the `local_osc` carrier.

## Interface
- `N`, 3: number of comb and integrator stages (1..6).
- `R`, 8: interpolation ratio; power of two, 2..1024. `LOG2R = $clog2(R)`.
- `IN_W`, 16: input sample width, signed.
- `OUT_W`, 16: output sample width, signed; `OUT_W <= IN_W`.
- `aclk` in 1: clock; all state is on the rising edge.
- `aresetn` in 1: asynchronous, active-low reset.
- `in` in IN_W: signed input sample.
- `in_valid` in 1: `in` is valid.
- `in_ready` out 1: the block takes a sample this cycle.
- `out` out OUT_W: signed output sample, one per clock.
- `out_valid` out 1: `out` carries filtered data.
- `underrun` out 1: sticky flag; a sample slot passed with `in_valid` low.

## Operation
- **Internal width:** `W = IN_W + N*LOG2R`. All comb and integrator arithmetic is two's-complement modulo 2^W, and wrap is intentional. The input is sign-extended to W.
- **Phase counter:** `phase` is `LOG2R` bits wide. It is 0 in reset, increments every cycle after reset, and wraps R-1 -> 0.
- **Input slot:** `in_ready = (phase == 0)`, combinational from the phase register. A transfer occurs when `in_ready && in_valid`.
- **Underrun:** at a slot with `in_valid` low, the comb input is 0 and `underrun` sets on the next cycle. It stays set until reset.
- **Comb section:** runs once per slot, with differential delay M = 1.
  - Stage k computes `c_k = c_{k-1} - d_k`, where `c_0` is the slot input.
  - `d_k` updates to `c_{k-1}` at each slot only.
  - The chain is combinational within the slot cycle. Its result is registered into `u` at the end of the slot cycle.
- **Zero-stuff:** `u` holds the comb result for exactly one cycle, the cycle after the slot. It is 0 in every other cycle.
- **Integrator section:** N registers, updated every cycle.
  - `I_1 <= I_1 + u`.
  - `I_k <= I_k + I_{k-1}` for k = 2..N, using register values (pipelined).
- **Scaling:** DC gain is R^(N-1).
  - `s = I_N >>> ((N-1)*LOG2R)` is arithmetic and has width `IN_W + LOG2R`.
  - The low IN_W bits of `s` are kept, giving `t`.
  - `out <= t[IN_W-1 -: OUT_W]`, registered.
- **Valid:** `out_valid` is 0 from reset until the first accepted sample reaches `out`. It is then 1 every cycle until the next reset.

## Timing
- **Reset values:** `out` = 0, `out_valid` = 0, `underrun` = 0, `phase` = 0; all comb, integrator and `u` registers are 0.
- **Reset release:** `in_ready` is 1 in the first cycle after `aresetn` is released, because `phase` = 0.
- **Latency:** a sample accepted in cycle t first affects `out` in cycle t+N+2: `u` at t+1, `I_1` at t+2, …, `I_N` at t+N+1, `out` at t+N+2.
- **First valid:** `out_valid` rises in cycle t0+N+2, where t0 is the first accepted slot.
- **Throughput:** one input per R cycles and one output per cycle. `in_ready` is never high two cycles in a row (R >= 2).
- **Mid-operation reset:** asserting `aresetn` low clears all state and outputs immediately, without waiting for a clock. After release, `phase` restarts at 0.
- **`in_valid` outside a slot:** ignored; `in_valid` is never an error when `in_ready` is 0.

## Configuration
- **`CIC_INTERP_SAT_EN` undefined:** `t` is a truncation of `s`, so out-of-range values (CIC overshoot near full scale) wrap.
- **`CIC_INTERP_SAT_EN` defined:** `s` is clamped to the IN_W signed range [-2^(IN_W-1), 2^(IN_W-1)-1] before the OUT_W bits are taken. Latency is unchanged.

## Test plan
All scenarios use N=3, R=8, IN_W=OUT_W=16.
- **Reset:** hold `aresetn` low for 5 cycles -> `out`=0, `out_valid`=0, `underrun`=0, `in_ready`=0 during reset; `in_ready`=1 in the first cycle after release, then every 8th cycle.
- **DC step:** present `in`=1000 with `in_valid` high continuously -> `out_valid` rises 5 cycles after the first accept; `out` settles to exactly 1000 within 30 cycles and stays at 1000.
- **Impulse:** one sample of 16384, then zeros ->
  - first nonzero `out` is 256, exactly 5 cycles after the accept;
  - exactly 22 nonzero outputs follow;
  - the outputs sum to 131072 (= 16384 × R).
- **Underrun:** drop `in_valid` for one slot mid-stream -> `underrun` rises the next cycle and stays 1; output matches a golden model fed 0 at that slot. Pulse `aresetn` -> `underrun` = 0.
- **Async reset mid-stream:** drive `aresetn` low between clock edges during the impulse response -> `out` and `out_valid` go to 0 before the next edge; after release, the phase restarts and the impulse test passes again.
- **Saturation:** alternate +32767/-32768 every slot ->
  - with `CIC_INTERP_SAT_EN`, `out` never wraps sign and clamps at 32767/-32768;
  - without it, `out` equals the wrapping golden model bit-exactly.
